seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexed driver for the 8-digit 7-segment display. It latches a
//  32-bit value through a load/busy handshake and shows it as 8 hex digits.
//  Sits directly downstream of the CPU debug/IO outputs (x19 value, lt data).
//  It scans one digit per SCAN_DIV clocks. New values swap in only at frame
//  boundaries, so a frame never shows a mix of old and new digits.
// PARAMETERS
//  SCAN_DIV  50000  clk cycles each digit stays lit (>=2)
//  LZ_BLANK  0      1 = blank leading zero digits; digit 0 is always shown
// PORTS
//  clk     in   1   system clock
//  rst     in   1   synchronous active-high reset
//  load    in   1   request to latch data/dp; accepted when load & !busy
//  data    in   32  value to show; data[4k+3:4k] drives digit k (k=0 rightmost)
//  dp      in   8   decimal point per digit, 1 = on; latched with data
//  busy    out  1   1 = a loaded value is waiting for the frame boundary
//  led_en  out  8   digit enables, active-low; led_en[k] selects digit k
//  seg     out  8   {ca,cb,cc,cd,ce,cf,cg,dp}, active-low
// BEHAVIOUR
//  Reset (sync, rst=1 at clk edge): div_cnt=0, idx=0, shadow=0, pend=0,
//   dp_sh=0, busy=0, led_en=8'hFF, seg=8'hFF. Reset clears any pending load.
//  Scan counter: div_cnt counts 0..SCAN_DIV-1 and wraps; tick = (div_cnt==SCAN_DIV-1).
//   On tick, idx <= idx+1 (3-bit, 7 wraps to 0). Frame = 8*SCAN_DIV clocks.
//  Frame boundary: a tick while idx==7.
//  Handshake: if load & !busy, capture data->pend and dp->pend_dp; busy<=1.
//   load while busy=1 is ignored; pend keeps its value.
//   At a frame boundary with busy=1: shadow<=pend, dp_sh<=pend_dp, busy<=0.
//   Load accepted in the same cycle as a boundary: captured, and applied at
//   the NEXT boundary, not this one. Max busy time is 8*SCAN_DIV clocks.
//  Outputs are registered, 1 clk after idx/shadow:
//   led_en <= ~(8'b1 << idx); seg <= {font(shadow nibble idx), ~dp_sh[idx]}.
//   Only one led_en bit is low at any time after the first post-reset cycle.
//  Font, {ca..cg} active-low:
//   0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000
//   7=0001111 8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010
//   E=0110000 F=0111000
//  LZ_BLANK=1: digit k>0 is blank (seg=8'hFF, dp too) when shadow[31:4k]==0.
//   Digit 0 is never blanked. The enable still scans normally.
//  No combinational path from load/data to any output.
// TESTING (SCAN_DIV=4 for sim)
//  1 Reset: assert rst 3 clk -> led_en=FF, seg=FF, busy=0. After release,
//    led_en cycles FE,FD,FB..7F, each held 4 clk, then repeats.
//  2 Load 32'h0123_4567 dp=0 mid-frame -> busy=1 until boundary, then 0. The
//    next frame shows digit0 seg=0x1F ('7'), digit7 seg=0x03 ('0'). The
//    old value is never mixed into the new frame.
//  3 Load A while busy=1, then load B -> frame shows A; B is ignored, busy
//    drops once, pend is unchanged.
//  4 Load asserted exactly on a boundary tick -> busy stays 1 for a full
//    frame (32 clk). New value appears from the following frame.
//  5 LZ_BLANK=1, data=32'h0000_00A0 -> digits 7..2 seg=FF, digit1=0x11
//    ('A'), digit0=0x03 ('0'). data=0 -> only digit0 shows '0'.
//  6 rst asserted while busy=1 mid-frame -> next clk busy=0, shadow=0,
//    led_en=FF. The pending value is never displayed.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit hex driver for the 7-segment display.
// A loaded value waits in a pending register and swaps in only at a frame boundary.
module seg7_scan_driver #(
    parameter int SCAN_DIV = 50000,
    parameter bit LZ_BLANK = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] data,
    input  logic [7:0]  dp,
    output logic        busy,
    output logic [7:0]  led_en,
    output logic [7:0]  seg
);

    localparam int                DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic {
        ST_IDLE,
        ST_PEND
    } hs_state_t;

    hs_state_t        state;
    hs_state_t        state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       idx;
    logic             tick;
    logic             frame_end;
    logic             capture;
    logic             apply;

    logic [31:0]      pend;
    logic [7:0]       pend_dp;
    logic [31:0]      shadow;
    logic [7:0]       dp_sh;

    logic [3:0]       nibble;
    logic [7:0]       blank_mask;
    logic [7:0]       seg_nxt;

    // {ca..cg}, active-low
    function automatic logic [6:0] font7(input logic [3:0] nib);
        logic [6:0] f;
        f = 7'b1111111;
        case (nib)
            4'h0: f = 7'b0000001;
            4'h1: f = 7'b1001111;
            4'h2: f = 7'b0010010;
            4'h3: f = 7'b0000110;
            4'h4: f = 7'b1001100;
            4'h5: f = 7'b0100100;
            4'h6: f = 7'b0100000;
            4'h7: f = 7'b0001111;
            4'h8: f = 7'b0000000;
            4'h9: f = 7'b0000100;
            4'hA: f = 7'b0001000;
            4'hB: f = 7'b1100000;
            4'hC: f = 7'b0110001;
            4'hD: f = 7'b1000010;
            4'hE: f = 7'b0110000;
            4'hF: f = 7'b0111000;
            default: f = 7'b1111111;
        endcase
        return f;
    endfunction

    assign tick      = (div_cnt == DIV_LAST);
    assign frame_end = tick && (idx == 3'd7);
    assign busy      = (state == ST_PEND);

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= 3'd0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick)
                idx <= idx + 3'd1;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        apply     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    capture   = 1'b1;
                    state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                // A load taken on a boundary cycle lands in ST_IDLE's branch,
                // so it waits for the following boundary.
                if (frame_end) begin
                    apply     = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: the value registers are flops, not a RAM, so they take the reset
    // too; otherwise the first frame after reset would show stale digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            pend    <= 32'd0;
            pend_dp <= 8'd0;
            shadow  <= 32'd0;
            dp_sh   <= 8'd0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                pend    <= data;
                pend_dp <= dp;
            end
            if (apply) begin
                shadow <= pend;
                dp_sh  <= pend_dp;
            end
        end
    end

    // Digit k>0 is a leading zero when everything from its nibble upward is zero.
    always_comb begin
        blank_mask = 8'd0;
        for (int k = 1; k < 8; k++)
            blank_mask[k] = ((shadow >> (4 * k)) == 32'd0);
    end

    always_comb begin
        nibble = shadow[{idx, 2'b00} +: 4];
        if (LZ_BLANK && blank_mask[idx])
            seg_nxt = 8'hFF;
        else
            seg_nxt = {font7(nibble), ~dp_sh[idx]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_en <= 8'hFF;
            seg    <= 8'hFF;
        end else begin
            led_en <= ~(8'b1 << idx);
            seg    <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=4; one instance plain, one with
// leading-zero blanking. k counts post-reset clock edges; frame m covers k=32m+1..32m+32.
module tb_seg7_scan_driver;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [31:0] data = 32'd0;
    logic [7:0]  dp = 8'd0;
    logic        busy;
    logic [7:0]  led_en;
    logic [7:0]  seg;

    logic        lz_load = 1'b0;
    logic [31:0] lz_data = 32'd0;
    logic [7:0]  lz_dp = 8'd0;
    logic        lz_busy;
    logic [7:0]  lz_led_en;
    logic [7:0]  lz_seg;

    int n_checks = 0;
    int n_errors = 0;
    int k = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.SCAN_DIV(SCAN_DIV), .LZ_BLANK(1'b0)) u_dut (
        .clk(clk), .rst(rst), .load(load), .data(data), .dp(dp),
        .busy(busy), .led_en(led_en), .seg(seg)
    );

    seg7_scan_driver #(.SCAN_DIV(SCAN_DIV), .LZ_BLANK(1'b1)) u_dut_lz (
        .clk(clk), .rst(rst), .load(lz_load), .data(lz_data), .dp(lz_dp),
        .busy(lz_busy), .led_en(lz_led_en), .seg(lz_seg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        k++;
    endtask

    task automatic run_to(input int target);
        while (k < target)
            step();
    endtask

    // exp holds {d7,...,d0} seg bytes; each digit is sampled on its last lit cycle.
    task automatic check_frame(input string tag, input bit use_lz, input int m,
                               input logic [63:0] exp);
        logic [7:0] one8;
        one8 = 8'd1;
        for (int d = 0; d < 8; d++) begin
            run_to(32 * m + 4 * d + 4);
            if (use_lz) begin
                check($sformatf("%s seg d%0d", tag, d), {24'd0, lz_seg}, {24'd0, exp[8*d +: 8]});
                check($sformatf("%s led_en d%0d", tag, d), {24'd0, lz_led_en}, {24'd0, ~(one8 << d)});
            end else begin
                check($sformatf("%s seg d%0d", tag, d), {24'd0, seg}, {24'd0, exp[8*d +: 8]});
                check($sformatf("%s led_en d%0d", tag, d), {24'd0, led_en}, {24'd0, ~(one8 << d)});
            end
        end
    endtask

    task automatic do_load(input logic [31:0] v, input logic [7:0] p);
        data = v;
        dp   = p;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic do_lz_load(input logic [31:0] v, input logic [7:0] p);
        lz_data = v;
        lz_dp   = p;
        lz_load = 1'b1;
        step();
        lz_load = 1'b0;
    endtask

    initial begin
        logic [7:0] one8;
        logic [7:0] exp_en;
        one8 = 8'd1;

        // 1: reset state, then the scan order and dwell
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset led_en", {24'd0, led_en}, 32'hFF);
        check("reset seg", {24'd0, seg}, 32'hFF);
        check("reset busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        k = 0;
        for (int i = 1; i <= 36; i++) begin
            step();
            exp_en = ~(one8 << (((i - 1) / 4) % 8));
            check($sformatf("scan led_en k=%0d", k), {24'd0, led_en}, {24'd0, exp_en});
        end

        // 2: mid-frame load waits for the boundary at k=64
        do_load(32'h0123_4567, 8'h00);
        check("t2 busy after load", {31'd0, busy}, 32'd1);
        run_to(40);
        check("t2 old digit1 before boundary", {24'd0, seg}, 32'h03);
        run_to(63);
        check("t2 busy before boundary", {31'd0, busy}, 32'd1);
        run_to(64);
        check("t2 busy after boundary", {31'd0, busy}, 32'd0);
        check_frame("t2", 1'b0, 2, 64'h03_9F_25_0D_99_49_41_1F);

        // 3: second load while busy is ignored
        run_to(100);
        do_load(32'h89AB_CDEF, 8'h01);
        check("t3 busy after A", {31'd0, busy}, 32'd1);
        run_to(104);
        do_load(32'h1111_1111, 8'hFF);
        check("t3 busy after B", {31'd0, busy}, 32'd1);
        run_to(127);
        check("t3 busy before boundary", {31'd0, busy}, 32'd1);
        run_to(128);
        check("t3 busy after boundary", {31'd0, busy}, 32'd0);
        check_frame("t3", 1'b0, 4, 64'h01_09_11_C1_63_85_61_70);
        run_to(164);
        check("t3 A kept next frame", {24'd0, seg}, 32'h70);
        check("t3 busy stays low", {31'd0, busy}, 32'd0);

        // 4: load on the boundary edge k=192 is held a full frame
        run_to(191);
        do_load(32'hFEDC_BA98, 8'h80);
        check("t4 busy on boundary", {31'd0, busy}, 32'd1);
        run_to(196);
        check("t4 old value this frame", {24'd0, seg}, 32'h70);
        run_to(223);
        check("t4 busy before next boundary", {31'd0, busy}, 32'd1);
        run_to(224);
        check("t4 busy after next boundary", {31'd0, busy}, 32'd0);
        check_frame("t4", 1'b0, 7, 64'h70_61_85_63_C1_11_09_01);

        // 6: reset while a value is pending drops it
        run_to(260);
        do_load(32'h5555_5555, 8'hFF);
        check("t6 busy pending", {31'd0, busy}, 32'd1);
        run_to(270);
        rst = 1'b1;
        step();
        check("t6 busy cleared", {31'd0, busy}, 32'd0);
        check("t6 led_en", {24'd0, led_en}, 32'hFF);
        check("t6 seg", {24'd0, seg}, 32'hFF);
        rst = 1'b0;
        k = 0;
        check_frame("t6", 1'b0, 0, 64'h03_03_03_03_03_03_03_03);
        run_to(36);
        check("t6 pending never shown", {24'd0, seg}, 32'h03);
        check("t6 busy stays low", {31'd0, busy}, 32'd0);

        // 5: leading-zero blanking, dp blanked with the digit
        run_to(40);
        do_lz_load(32'h0000_00A0, 8'hFF);
        check("t5 lz busy", {31'd0, lz_busy}, 32'd1);
        check_frame("t5a", 1'b1, 2, 64'hFF_FF_FF_FF_FF_FF_10_02);
        run_to(100);
        do_lz_load(32'h0000_0000, 8'h00);
        check_frame("t5b", 1'b1, 4, 64'hFF_FF_FF_FF_FF_FF_FF_03);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
